// File: rtl/boreal_mmio_master.sv
// Byte-stream command parser that drives the inference core's MMIO register port.
// Define BOREAL_MMIO_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module boreal_mmio_master #(
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic [7:0]  rsp_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [9:0]  reg_addr,
   output logic [31:0] reg_din,
   output logic        reg_we,
   input  logic [31:0] reg_dout,
   output logic        busy,
   output logic [7:0]  err_count
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

`ifdef BOREAL_MMIO_CHECKSUM_EN
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_CHK, S_WRITE, S_READ, S_RSP, S_NAK
   } state_t;
`else
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_WRITE, S_READ, S_RSP, S_NAK
   } state_t;
`endif

   state_t        state;
   logic          running;
   logic          is_write;
   logic [1:0]    addr_hi;
   logic [1:0]    byte_cnt;
   logic [9:0]    addr_reg;
   logic [31:0]   data_reg;
   logic [31:0]   rsp_shift;
   logic [2:0]    rsp_cnt;
   logic [TW-1:0] timer;
   logic          in_frame;
   logic          accept;
   logic          timed_out;
   logic [31:0]   data_next;
`ifdef BOREAL_MMIO_CHECKSUM_EN
   logic [7:0]    chk;
`endif

   always_comb begin
      in_frame = (state == S_ADDR_HI) || (state == S_ADDR_LO) || (state == S_DATA);
`ifdef BOREAL_MMIO_CHECKSUM_EN
      if (state == S_CHK) in_frame = 1'b1;
`endif
   end

   // running keeps cmd_ready low while reset is held and for no longer.
   assign cmd_ready = running && (in_frame || (state == S_IDLE));
   assign accept    = cmd_valid && cmd_ready;
   assign timed_out = in_frame && !accept && (timer == TIMER_LAST);
   assign data_next = {data_reg[23:0], cmd_data};
   assign rsp_data  = rsp_shift[31:24];
   assign rsp_valid = (state == S_RSP);
   assign reg_we    = (state == S_WRITE);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         running   <= 1'b0;
         is_write  <= 1'b0;
         addr_hi   <= '0;
         byte_cnt  <= '0;
         addr_reg  <= '0;
         data_reg  <= '0;
         rsp_shift <= '0;
         rsp_cnt   <= '0;
         timer     <= '0;
         reg_addr  <= '0;
         reg_din   <= '0;
         err_count <= '0;
`ifdef BOREAL_MMIO_CHECKSUM_EN
         chk       <= '0;
`endif
      end else begin
         running <= 1'b1;
         timer   <= (in_frame && !accept) ? timer + TW'(1) : '0;
         case (state)
            S_IDLE: if (accept) begin
               is_write <= (cmd_data == 8'hA5);
               state    <= ((cmd_data == 8'hA5) || (cmd_data == 8'h5A)) ? S_ADDR_HI : S_NAK;
`ifdef BOREAL_MMIO_CHECKSUM_EN
               chk      <= cmd_data;
`endif
            end
            S_ADDR_HI: if (accept) begin
               addr_hi <= cmd_data[1:0];
               state   <= S_ADDR_LO;
`ifdef BOREAL_MMIO_CHECKSUM_EN
               chk     <= chk ^ cmd_data;
`endif
            end else if (timed_out) state <= S_NAK;
            S_ADDR_LO: if (accept) begin
               addr_reg <= {addr_hi, cmd_data};
               byte_cnt <= 2'd0;
`ifdef BOREAL_MMIO_CHECKSUM_EN
               chk      <= chk ^ cmd_data;
               state    <= is_write ? S_DATA : S_CHK;
`else
               if (is_write) begin
                  state <= S_DATA;
               end else begin
                  reg_addr <= {addr_hi, cmd_data};
                  state    <= S_READ;
               end
`endif
            end else if (timed_out) state <= S_NAK;
            S_DATA: if (accept) begin
               data_reg <= data_next;
               byte_cnt <= byte_cnt + 2'd1;
`ifdef BOREAL_MMIO_CHECKSUM_EN
               chk      <= chk ^ cmd_data;
               if (byte_cnt == 2'd3) state <= S_CHK;
`else
               if (byte_cnt == 2'd3) begin
                  reg_addr <= addr_reg;
                  reg_din  <= data_next;
                  state    <= S_WRITE;
               end
`endif
            end else if (timed_out) state <= S_NAK;
`ifdef BOREAL_MMIO_CHECKSUM_EN
            // The register port is only touched once the checksum has matched.
            S_CHK: if (accept) begin
               if (cmd_data != chk) begin
                  state <= S_NAK;
               end else begin
                  reg_addr <= addr_reg;
                  if (is_write) begin
                     reg_din <= data_reg;
                     state   <= S_WRITE;
                  end else begin
                     state <= S_READ;
                  end
               end
            end else if (timed_out) state <= S_NAK;
`endif
            S_WRITE: begin
               rsp_shift <= {8'h06, 24'h0};
               rsp_cnt   <= 3'd1;
               state     <= S_RSP;
            end
            S_READ: begin
               rsp_shift <= reg_dout;
               rsp_cnt   <= 3'd4;
               state     <= S_RSP;
            end
            S_NAK: begin
               rsp_shift <= {8'h15, 24'h0};
               rsp_cnt   <= 3'd1;
               if (err_count != 8'hFF) err_count <= err_count + 8'd1;
               state     <= S_RSP;
            end
            S_RSP: if (rsp_ready) begin
               if (rsp_cnt == 3'd1) begin
                  state <= S_IDLE;
               end else begin
                  rsp_shift <= {rsp_shift[23:0], 8'h00};
                  rsp_cnt   <= rsp_cnt - 3'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_boreal_mmio_master.sv
// Self-checking bench for boreal_mmio_master: random frames checked against a register-map model.
`timescale 1ns/1ps
module tb_boreal_mmio_master;
   localparam int TIMEOUT_CYC = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  cmd_data = 8'h00;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  rsp_data;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [9:0]  reg_addr;
   logic [31:0] reg_din;
   logic        reg_we;
   logic [31:0] reg_dout;
   logic        busy;
   logic [7:0]  err_count;

   boreal_mmio_master #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .reg_addr(reg_addr), .reg_din(reg_din), .reg_we(reg_we), .reg_dout(reg_dout),
      .busy(busy), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int          n_compared = 0;
   int          n_mismatched = 0;
   logic [31:0] core_mem [0:1023];
   logic [31:0] model_mem [0:1023];
   logic        mem_ready = 1'b0;
   int          we_count = 0;
   int          we_long = 0;
   logic        we_prev = 1'b0;
   logic [9:0]  last_we_addr = '0;
   logic [31:0] last_we_din = '0;
   logic [7:0]  tx_q [$];
   logic [7:0]  rx_q [$];
   int          unstable = 0;
   int          ready_leak = 0;
   int          exp_err = 0;
   int          exp_we = 0;
   logic [7:0]  last_chk = 8'h00;

   function automatic logic [31:0] init_val(input int i);
      if (i == 16) return 32'h0000_1234;
      return (32'(i) * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   // Core register file: combinational read, written on each reg_we strobe.
   assign reg_dout = core_mem[reg_addr];

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) core_mem[i] <= init_val(i);
         mem_ready <= 1'b1;
      end else if (reg_we) begin
         core_mem[reg_addr] <= reg_din;
         we_count     <= we_count + 1;
         last_we_addr <= reg_addr;
         last_we_din  <= reg_din;
      end
      if (reg_we && we_prev) we_long <= we_long + 1;
      we_prev <= reg_we;
   end

   task automatic send_byte(input logic [7:0] b);
      bit done;
      done = 1'b0;
      cmd_data  = b;
      cmd_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      cmd_valid = 1'b0;
      if (!done) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL cmd_accept: byte %h not accepted, cmd_ready=%b, required 1", b, cmd_ready);
      end
   endtask

   task automatic send_frame(input bit with_chk, input bit corrupt);
      logic [7:0] x;
      x = 8'h00;
      foreach (tx_q[i]) begin
         send_byte(tx_q[i]);
         x = x ^ tx_q[i];
      end
`ifdef BOREAL_MMIO_CHECKSUM_EN
      if (with_chk) send_byte(x ^ {7'd0, corrupt});
`else
      last_chk = with_chk ? (x ^ {7'd0, corrupt}) : 8'h00;
`endif
   endtask

   task automatic recv_bytes(input int n, input int stall);
      int         w;
      logic [7:0] held;
      rx_q.delete();
      for (int k = 0; k < n; k++) begin
         w = 0;
         @(negedge clk);
         while (!rsp_valid && w < 4 * TIMEOUT_CYC) begin
            @(negedge clk);
            w++;
         end
         if (!rsp_valid) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, w);
            return;
         end
         held = rsp_data;
         for (int s = 0; s < stall; s++) begin
            if (rsp_data !== held || rsp_valid !== 1'b1) unstable++;
            if (cmd_ready !== 1'b0) ready_leak++;
            @(negedge clk);
         end
         if (rsp_data !== held || rsp_valid !== 1'b1) unstable++;
         if (cmd_ready !== 1'b0) ready_leak++;
         rx_q.push_back(rsp_data);
         rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         rsp_ready = 1'b0;
      end
   endtask

   task automatic run_write(input logic [7:0] hi, input logic [7:0] lo, input logic [31:0] d,
                            input int stall);
      tx_q = '{8'hA5, hi, lo, d[31:24], d[23:16], d[15:8], d[7:0]};
      send_frame(1'b1, 1'b0);
      recv_bytes(1, stall);
   endtask

   task automatic run_read(input logic [7:0] hi, input logic [7:0] lo, input int stall);
      tx_q = '{8'h5A, hi, lo};
      send_frame(1'b1, 1'b0);
      recv_bytes(4, stall);
   endtask

   function automatic logic [31:0] rx_word();
      if (rx_q.size() != 4) return 32'hDEAD_BEEF ^ 32'(rx_q.size());
      return {rx_q[0], rx_q[1], rx_q[2], rx_q[3]};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_compared++;
      if ({cmd_ready, rsp_valid, rsp_data, reg_addr, reg_din, reg_we, busy, err_count} !== 62'd0) begin
         n_mismatched++;
         $display("[TB] FAIL reset_values: ready=%b valid=%b data=%h addr=%h din=%h we=%b busy=%b err=%0d, required all 0",
                  cmd_ready, rsp_valid, rsp_data, reg_addr, reg_din, reg_we, busy, err_count);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_compared++;
      if ({cmd_ready, busy} !== 2'b10) begin
         n_mismatched++;
         $display("[TB] FAIL ready_after_reset: ready=%b busy=%b, required 1 0", cmd_ready, busy);
      end
   endtask

   task automatic test_write_spec();
      tx_q = '{8'hA5, 8'h00, 8'h02, 8'h0B, 8'hEB, 8'hC2, 8'h00};
      send_frame(1'b1, 1'b0);
      n_compared++;
      if ({reg_we, reg_addr, reg_din} !== {1'b1, 10'h002, 32'h0BEB_C200}) begin
         n_mismatched++;
         $display("[TB] FAIL write_strobe: we=%b addr=%h din=%h, required 1 002 0bebc200", reg_we, reg_addr, reg_din);
      end
      @(posedge clk);
      #1;
      n_compared++;
      if ({rsp_valid, reg_we} !== 2'b10) begin
         n_mismatched++;
         $display("[TB] FAIL write_rsp_timing: valid=%b we=%b, required 1 0", rsp_valid, reg_we);
      end
      recv_bytes(1, 0);
      model_mem[2] = 32'h0BEB_C200;
      exp_we++;
      n_compared++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h06) begin
         n_mismatched++;
         $display("[TB] FAIL write_ack: got %0d bytes first=%h, required 1 byte 06", rx_q.size(), rsp_data);
      end
      n_compared++;
      if (we_count !== exp_we || we_long !== 0 || err_count !== 8'(exp_err)) begin
         n_mismatched++;
         $display("[TB] FAIL write_side: writes=%0d long=%0d err=%0d, required %0d 0 %0d",
                  we_count, we_long, err_count, exp_we, exp_err);
      end
   endtask

   task automatic test_read_spec();
      tx_q = '{8'h5A, 8'h00, 8'h10};
      send_frame(1'b1, 1'b0);
      n_compared++;
      if ({reg_we, reg_addr, rsp_valid} !== {1'b0, 10'h010, 1'b0}) begin
         n_mismatched++;
         $display("[TB] FAIL read_addr: we=%b addr=%h valid=%b, required 0 010 0", reg_we, reg_addr, rsp_valid);
      end
      @(posedge clk);
      #1;
      n_compared++;
      if ({rsp_valid, rsp_data} !== {1'b1, 8'h00}) begin
         n_mismatched++;
         $display("[TB] FAIL read_rsp_timing: valid=%b data=%h, required 1 00", rsp_valid, rsp_data);
      end
      recv_bytes(4, 0);
      n_compared++;
      if (rx_word() !== 32'h0000_1234) begin
         n_mismatched++;
         $display("[TB] FAIL read_data: got %h, required 00001234", rx_word());
      end
      n_compared++;
      if (we_count !== exp_we) begin
         n_mismatched++;
         $display("[TB] FAIL read_no_write: writes=%0d, required %0d", we_count, exp_we);
      end
   endtask

   task automatic test_bad_opcode();
      logic [7:0] lo;
      tx_q = '{8'h33};
      send_frame(1'b0, 1'b0);
      recv_bytes(1, 0);
      exp_err++;
      n_compared++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h15 || err_count !== 8'(exp_err) || we_count !== exp_we) begin
         n_mismatched++;
         $display("[TB] FAIL bad_opcode: bytes=%0d err=%0d writes=%0d, required 15 err=%0d writes=%0d",
                  rx_q.size(), err_count, we_count, exp_err, exp_we);
      end
      lo = 8'($urandom);
      run_read(8'h03, lo, 0);
      n_compared++;
      if (rx_word() !== model_mem[{2'b11, lo}]) begin
         n_mismatched++;
         $display("[TB] FAIL read_after_nak: got %h, required %h", rx_word(), model_mem[{2'b11, lo}]);
      end
   endtask

   task automatic test_timeout();
      logic [7:0]  lo;
      logic [31:0] d;
      tx_q = '{8'hA5, 8'h01};
      send_frame(1'b0, 1'b0);
      repeat (TIMEOUT_CYC - 5) @(posedge clk);
      #1;
      n_compared++;
      if ({busy, rsp_valid, cmd_ready} !== 3'b101) begin
         n_mismatched++;
         $display("[TB] FAIL timeout_early: busy=%b valid=%b ready=%b, required 1 0 1", busy, rsp_valid, cmd_ready);
      end
      recv_bytes(1, 0);
      exp_err++;
      n_compared++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h15 || busy !== 1'b0 || we_count !== exp_we
          || err_count !== 8'(exp_err)) begin
         n_mismatched++;
         $display("[TB] FAIL timeout_nak: bytes=%0d busy=%b writes=%0d err=%0d, required 15 0 %0d %0d",
                  rx_q.size(), busy, we_count, err_count, exp_we, exp_err);
      end
      lo = 8'($urandom);
      d  = $urandom;
      run_write(8'h01, lo, d, 0);
      model_mem[{2'b01, lo}] = d;
      exp_we++;
      run_read(8'hFD, lo, 1);
      n_compared++;
      if (rx_word() !== d || we_count !== exp_we) begin
         n_mismatched++;
         $display("[TB] FAIL frame_after_timeout: got %h writes=%0d, required %h %0d", rx_word(), we_count, d, exp_we);
      end
   endtask

   task automatic test_stall_read();
      logic [7:0] hi, lo;
      hi = 8'($urandom);
      lo = 8'($urandom);
      unstable   = 0;
      ready_leak = 0;
      run_read(hi, lo, 10);
      n_compared++;
      if (rx_word() !== model_mem[{hi[1:0], lo}] || unstable !== 0 || ready_leak !== 0) begin
         n_mismatched++;
         $display("[TB] FAIL stall_read: got %h unstable=%0d ready_leak=%0d, required %h 0 0",
                  rx_word(), unstable, ready_leak, model_mem[{hi[1:0], lo}]);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] lo;
      lo = 8'($urandom);
      run_read(8'h00, lo, 0);
      n_compared++;
      if ({cmd_ready, busy} !== 2'b10) begin
         n_mismatched++;
         $display("[TB] FAIL idle_after_last: ready=%b busy=%b, required 1 0", cmd_ready, busy);
      end
      run_read(8'h00, lo, 0);
      n_compared++;
      if (rx_word() !== model_mem[{2'b00, lo}]) begin
         n_mismatched++;
         $display("[TB] FAIL back_to_back: got %h, required %h", rx_word(), model_mem[{2'b00, lo}]);
      end
   endtask

   task automatic test_random();
      int          kind, stall;
      logic [7:0]  hi, lo, op;
      logic [9:0]  a;
      logic [31:0] d;
      for (int it = 0; it < 40; it++) begin
         kind  = $urandom_range(0, 9);
         stall = $urandom_range(0, 3);
         hi    = 8'($urandom);
         lo    = 8'($urandom);
         a     = {hi[1:0], lo};
         d     = $urandom;
         if (kind < 4) begin
            run_write(hi, lo, d, stall);
            model_mem[a] = d;
            exp_we++;
            n_compared++;
            if (rx_q.size() != 1 || rx_q[0] !== 8'h06 || {last_we_addr, last_we_din} !== {a, d}) begin
               n_mismatched++;
               $display("[TB] FAIL rand_write %0d: bytes=%0d addr=%h din=%h, required 06 %h %h",
                        it, rx_q.size(), last_we_addr, last_we_din, a, d);
            end
         end else if (kind < 8) begin
            run_read(hi, lo, stall);
            n_compared++;
            if (rx_word() !== model_mem[a]) begin
               n_mismatched++;
               $display("[TB] FAIL rand_read %0d: addr=%h got %h, required %h", it, a, rx_word(), model_mem[a]);
            end
         end else begin
            op = hi;
            if (op == 8'hA5 || op == 8'h5A) op = 8'h00;
            tx_q = '{op};
            send_frame(1'b0, 1'b0);
            recv_bytes(1, stall);
            exp_err++;
            n_compared++;
            if (rx_q.size() != 1 || rx_q[0] !== 8'h15) begin
               n_mismatched++;
               $display("[TB] FAIL rand_nak %0d: opcode %h gave %0d bytes, required 15", it, op, rx_q.size());
            end
         end
         n_compared++;
         if (we_count !== exp_we || err_count !== 8'(exp_err) || we_long !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL rand_counts %0d: writes=%0d err=%0d long=%0d, required %0d %0d 0",
                     it, we_count, err_count, we_long, exp_we, exp_err);
         end
      end
   endtask

   task automatic test_reset_midframe();
      tx_q = '{8'hA5, 8'h01, 8'h23, 8'h11, 8'h22};
      send_frame(1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      n_compared++;
      if ({cmd_ready, rsp_valid, rsp_data, reg_addr, reg_din, reg_we, busy, err_count} !== 62'd0) begin
         n_mismatched++;
         $display("[TB] FAIL midframe_reset: ready=%b valid=%b addr=%h din=%h we=%b busy=%b err=%0d, required all 0",
                  cmd_ready, rsp_valid, reg_addr, reg_din, reg_we, busy, err_count);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      exp_err = 0;
      @(posedge clk);
      #1;
      n_compared++;
      if (we_count !== exp_we || {cmd_ready, rsp_valid} !== 2'b10) begin
         n_mismatched++;
         $display("[TB] FAIL midframe_recover: writes=%0d ready=%b valid=%b, required %0d 1 0",
                  we_count, cmd_ready, rsp_valid, exp_we);
      end
      run_read(8'h01, 8'h23, 0);
      n_compared++;
      if (rx_word() !== model_mem[10'h123]) begin
         n_mismatched++;
         $display("[TB] FAIL midframe_no_write: got %h, required %h", rx_word(), model_mem[10'h123]);
      end
   endtask

`ifdef BOREAL_MMIO_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0]  lo;
      logic [31:0] d;
      lo = 8'($urandom);
      d  = ~model_mem[{2'b10, lo}];
      tx_q = '{8'hA5, 8'h02, lo, d[31:24], d[23:16], d[15:8], d[7:0]};
      send_frame(1'b1, 1'b1);
      recv_bytes(1, 0);
      exp_err++;
      n_compared++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h15 || we_count !== exp_we || err_count !== 8'(exp_err)) begin
         n_mismatched++;
         $display("[TB] FAIL bad_checksum: bytes=%0d writes=%0d err=%0d, required 15 %0d %0d",
                  rx_q.size(), we_count, err_count, exp_we, exp_err);
      end
      run_read(8'h02, lo, 0);
      n_compared++;
      if (rx_word() !== model_mem[{2'b10, lo}]) begin
         n_mismatched++;
         $display("[TB] FAIL checksum_no_write: got %h, required %h", rx_word(), model_mem[{2'b10, lo}]);
      end
   endtask
`endif

   task automatic test_err_saturate();
      for (int i = 0; i < 260; i++) begin
         tx_q = '{8'hFF};
         send_frame(1'b0, 1'b0);
         recv_bytes(1, 0);
         if (exp_err < 255) exp_err++;
      end
      n_compared++;
      if (err_count !== 8'(exp_err) || exp_err != 255) begin
         n_mismatched++;
         $display("[TB] FAIL err_saturate: err=%0d, required 255", err_count);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) model_mem[i] = init_val(i);
      test_reset();
      test_write_spec();
      test_read_spec();
      test_bad_opcode();
      test_timeout();
      test_stall_read();
      test_back_to_back();
      test_random();
      test_reset_midframe();
`ifdef BOREAL_MMIO_CHECKSUM_EN
      test_checksum();
`endif
      test_err_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
